// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding and the MISR step function,
// used by the checker and by any bench that computes golden signatures.
package bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_t;

  // Galois MISR step for any width up to 64; bits above 'width' are cleared.
  function automatic logic [63:0] misr_next(input logic [63:0] s,
                                            input logic [63:0] d,
                                            input logic [63:0] poly,
                                            input int unsigned width);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    r = {s[62:0], 1'b0} ^ (s[6'(width - 1)] ? poly : 64'd0) ^ d;
    return r & mask;
  endfunction

endpackage

// File: rtl/misr_checker_if.sv
// Response/signature bundle between the DUT-output side and the MISR checker.
interface misr_checker_if #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 40
);
  localparam int CW = $clog2(WINDOW + 1);

  logic             start;
  logic             en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] signature;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    output start, en, data_in, golden,
    input  signature, count, busy, done, pass
  );

  modport slave (
    input  start, en, data_in, golden,
    output signature, count, busy, done, pass
  );

endinterface

// File: rtl/misr_checker.sv
// Compacts a fixed window of accepted response words into a MISR and compares
// the final signature against a golden value.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; waiting for start
//   RUN   | compacting data_in on every en until WINDOW samples accepted
//   DONE  | signature/count/pass frozen; start reseeds and reruns
module misr_checker
  import bist_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] POLY   = 32'h04C11DB7,
  parameter logic [WIDTH-1:0] SEED   = 32'hFFFFFFFF,
  parameter int               WINDOW = 40
) (
  input logic            clk,
  input logic            reset,
  misr_checker_if.slave  bus
);

  localparam int CW = $clog2(WINDOW + 1);

  bist_state_t      state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d, sig_step;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign sig_step = WIDTH'(misr_next(64'(sig_q), 64'(bus.data_in), 64'(POLY), WIDTH));

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        // The word on data_in during the start cycle is deliberately dropped.
        if (bus.start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.en) begin
          sig_d = sig_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WINDOW - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_step == bus.golden);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.signature = sig_q;
  assign bus.count     = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_misr_checker.sv
// Directed bench for misr_checker: two instances (WINDOW=2/SEED=00 and
// WINDOW=1/SEED=80), WIDTH=8, POLY=07, hand-computed signatures.
module tb_misr_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  misr_checker_if #(.WIDTH(8), .WINDOW(2)) bus_a ();
  misr_checker_if #(.WIDTH(8), .WINDOW(1)) bus_b ();

  misr_checker #(.WIDTH(8), .POLY(8'h07), .SEED(8'h00), .WINDOW(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  misr_checker #(.WIDTH(8), .POLY(8'h07), .SEED(8'h80), .WINDOW(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // {signature, count, busy, done, pass}
  logic [12:0] obs_a;
  logic [11:0] obs_b;
  assign obs_a = {bus_a.signature, bus_a.count, bus_a.busy, bus_a.done, bus_a.pass};
  assign obs_b = {bus_b.signature, bus_b.count, bus_b.busy, bus_b.done, bus_b.pass};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic s, input logic e, input logic [7:0] d);
    bus_a.start   = s;
    bus_a.en      = e;
    bus_a.data_in = d;
  endtask

  task automatic test_reset();
    logic [12:0] exp_a;
    logic [11:0] exp_b;
    reset = 1'b1;
    tick();
    tick();
    exp_a = {8'h00, 2'd0, 3'b000};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL reset_a: got %h want %h", obs_a, exp_a);
    end
    exp_b = {8'h80, 1'b0, 3'b000};
    vectors++;
    if (obs_b !== exp_b) begin
      miscompares++;
      $display("FAIL reset_b: got %h want %h", obs_b, exp_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_pass();
    logic [12:0] exp_a;
    bus_a.golden = 8'h00;
    drive_a(1'b1, 1'b0, 8'h00);
    tick();
    exp_a = {8'h00, 2'd0, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL pass_start: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b1, 8'h01);
    tick();
    exp_a = {8'h01, 2'd1, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL pass_sample1: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b1, 8'h02);
    tick();
    exp_a = {8'h00, 2'd2, 3'b011};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL pass_done: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b0, 8'h00);
    tick();
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL pass_hold: got %h want %h", obs_a, exp_a);
    end
  endtask

  task automatic test_fail();
    logic [12:0] exp_a;
    drive_a(1'b1, 1'b0, 8'h00);
    tick();
    exp_a = {8'h00, 2'd0, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL fail_restart: got %h want %h", obs_a, exp_a);
    end
    // golden matches mid-run but is changed before the final sample edge
    bus_a.golden = 8'h00;
    drive_a(1'b0, 1'b1, 8'h01);
    tick();
    exp_a = {8'h01, 2'd1, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL fail_sample1: got %h want %h", obs_a, exp_a);
    end
    bus_a.golden = 8'h5A;
    drive_a(1'b0, 1'b1, 8'h02);
    tick();
    exp_a = {8'h00, 2'd2, 3'b010};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL fail_done: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_window_one();
    logic [11:0] exp_b;
    bus_b.golden  = 8'h07;
    bus_b.start   = 1'b1;
    bus_b.en      = 1'b0;
    bus_b.data_in = 8'h00;
    tick();
    exp_b = {8'h80, 1'b0, 3'b100};
    vectors++;
    if (obs_b !== exp_b) begin
      miscompares++;
      $display("FAIL w1_start: got %h want %h", obs_b, exp_b);
    end
    bus_b.start = 1'b0;
    bus_b.en    = 1'b1;
    tick();
    exp_b = {8'h07, 1'b1, 3'b011};
    vectors++;
    if (obs_b !== exp_b) begin
      miscompares++;
      $display("FAIL w1_done: got %h want %h", obs_b, exp_b);
    end
    bus_b.data_in = 8'h33;
    tick();
    vectors++;
    if (obs_b !== exp_b) begin
      miscompares++;
      $display("FAIL w1_frozen: got %h want %h", obs_b, exp_b);
    end
    bus_b.en = 1'b0;
  endtask

  task automatic test_gap_reset();
    logic [12:0] exp_a;
    bus_a.golden = 8'h00;
    drive_a(1'b1, 1'b0, 8'h00);
    tick();
    drive_a(1'b0, 1'b1, 8'h01);
    tick();
    exp_a = {8'h01, 2'd1, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL gap_sample1: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b0, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_a !== exp_a) begin
        miscompares++;
        $display("FAIL gap_hold%0d: got %h want %h", i, obs_a, exp_a);
      end
    end
    // reset mid-run with start/en asserted: reset must win
    reset = 1'b1;
    drive_a(1'b1, 1'b1, 8'h77);
    tick();
    exp_a = {8'h00, 2'd0, 3'b000};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL gap_reset: got %h want %h", obs_a, exp_a);
    end
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 8'h00);
    tick();
    drive_a(1'b0, 1'b1, 8'h01);
    tick();
    drive_a(1'b0, 1'b1, 8'h02);
    tick();
    exp_a = {8'h00, 2'd2, 3'b011};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL gap_rerun: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_start_overlap();
    logic [12:0] exp_a;
    bus_a.golden = 8'h00;
    drive_a(1'b1, 1'b1, 8'hFF);
    tick();
    exp_a = {8'h00, 2'd0, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL ovl_start_data: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b1, 1'b1, 8'h01);
    tick();
    exp_a = {8'h01, 2'd1, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL ovl_start_in_run: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b1, 1'b1, 8'h02);
    tick();
    exp_a = {8'h00, 2'd2, 3'b011};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL ovl_done: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b1, 8'h55);
    tick();
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL ovl_en_in_done: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b1, 1'b0, 8'h00);
    tick();
    exp_a = {8'h00, 2'd0, 3'b100};
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL ovl_restart: got %h want %h", obs_a, exp_a);
    end
    drive_a(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 8'h00);
    bus_a.golden  = 8'h00;
    bus_b.start   = 1'b0;
    bus_b.en      = 1'b0;
    bus_b.data_in = 8'h00;
    bus_b.golden  = 8'h00;
    test_reset();
    test_pass();
    test_fail();
    test_window_one();
    test_gap_reset();
    test_start_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
